// File: rtl/async_fifo_pkg.sv
// Shared types and sizing for the async FIFO read-side drain engine.
//   reader_state_e : drain FSM states
//   SKID_DEPTH     : entries in the output skid buffer
//   OCC_WIDTH      : width of a skid-buffer occupancy count (0..SKID_DEPTH)
//   PTR_WIDTH      : width of a skid-buffer head/tail pointer
//   CREDIT_WIDTH   : width of the pop-credit sum (occ + inflight - pop_out)
package async_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  localparam int unsigned SKID_DEPTH   = 2;
  localparam int unsigned OCC_WIDTH    = $clog2(SKID_DEPTH + 1);
  localparam int unsigned PTR_WIDTH    = $clog2(SKID_DEPTH);
  localparam int unsigned CREDIT_WIDTH = OCC_WIDTH + 1;

endpackage

// File: rtl/skid_buffer.sv
// Small register FIFO that catches words returned by the async FIFO so that
// the output stream can stall without losing data already in flight.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_wr_en      : push i_wr_data at the tail
//   i_wr_data    : word to push
//   i_rd_en      : pop the head (caller guarantees occupancy != 0)
//   o_rd_data    : current head word
//   o_occ        : number of stored words
module skid_buffer
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [OCC_WIDTH-1:0]  o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic [PTR_WIDTH-1:0]  r_head;
  logic [PTR_WIDTH-1:0]  r_tail;
  logic [OCC_WIDTH-1:0]  r_occ;

  // Storage, pointers and occupancy; a simultaneous push and pop keeps occ.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem  <= '{default: '0};
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_tail] <= i_wr_data;
        r_tail        <= r_tail + PTR_WIDTH'(1);
      end
      if (i_rd_en) begin
        r_head <= r_head + PTR_WIDTH'(1);
      end
      if (i_wr_en && !i_rd_en) begin
        r_occ <= r_occ + OCC_WIDTH'(1);
      end else if (!i_wr_en && i_rd_en) begin
        r_occ <= r_occ - OCC_WIDTH'(1);
      end
    end
  end

  assign o_rd_data = r_mem[r_head];
  assign o_occ     = r_occ;

  // The pop-credit logic upstream must keep these from ever firing.
  a_occ_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    r_occ <= OCC_WIDTH'(SKID_DEPTH));
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_wr_en && !i_rd_en && (r_occ == OCC_WIDTH'(SKID_DEPTH))));
  a_no_underrun: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_rd_en && (r_occ == '0)));

endmodule

// File: rtl/async_fifo_reader.sv
// Read-side drain engine: pops the async FIFO read port, absorbs its one-cycle
// read latency and presents the words as a valid/ready stream.
// Ports:
//   r_clk, rrst     : read-domain clock, synchronous active-high reset
//   enable          : permit new FIFO pops
//   fifo_empty      : FIFO empty flag
//   fifo_data       : FIFO data_out, valid the cycle after a pop
//   fifo_read_error : FIFO read_error, aligned with fifo_data
//   fifo_r_en       : FIFO pop strobe (combinational, depends on m_ready)
//   m_valid/m_data  : output stream word
//   m_ready         : consumer accepts the output word
//   rd_count        : words delivered, wrapping
//   busy            : FSM not idle
//   underflow_err   : sticky, FIFO rejected a pop
module async_fifo_reader
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_read_error,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy,
  output logic                  underflow_err
);

  reader_state_e           r_state;
  reader_state_e           w_state_nxt;
  logic                    r_inflight;
  logic [CNT_WIDTH-1:0]    r_rd_count;
  logic                    r_underflow;
  logic [OCC_WIDTH-1:0]    w_occ;
  logic                    w_pop_out;
  logic                    w_wr_en;
  logic                    w_fifo_r_en;
  logic [CREDIT_WIDTH-1:0] w_credit;

  assign w_pop_out = m_valid && m_ready;
  assign w_wr_en   = r_inflight && !fifo_read_error;

  // Slots already spoken for once this cycle's output handshake completes.
  // pop_out implies occ >= 1, so the subtraction never wraps.
  assign w_credit = CREDIT_WIDTH'(w_occ) + CREDIT_WIDTH'(r_inflight)
                  - CREDIT_WIDTH'(w_pop_out);

  // State register.
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pop strobe; pops only in RUN with buffer room guaranteed.
  always_comb begin
    w_state_nxt = r_state;
    w_fifo_r_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = RUN;
      end
      RUN: begin
        if (!enable) w_state_nxt = DRAIN;
        if (!fifo_empty && (w_credit < CREDIT_WIDTH'(SKID_DEPTH))) begin
          w_fifo_r_en = 1'b1;
        end
      end
      DRAIN: begin
        if (enable) begin
          w_state_nxt = RUN;
        end else if ((w_occ == '0) && !r_inflight) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // In-flight tracking, delivered-word counter and sticky error flag.
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      r_inflight  <= 1'b0;
      r_rd_count  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_inflight <= w_fifo_r_en;
      if (w_pop_out) begin
        r_rd_count <= r_rd_count + CNT_WIDTH'(1);
      end
      if (r_inflight && fifo_read_error) begin
        r_underflow <= 1'b1;
      end
    end
  end

  skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk     (r_clk),
    .i_rst     (rrst),
    .i_wr_en   (w_wr_en),
    .i_wr_data (fifo_data),
    .i_rd_en   (w_pop_out),
    .o_rd_data (m_data),
    .o_occ     (w_occ)
  );

  assign fifo_r_en     = w_fifo_r_en;
  assign m_valid       = (w_occ != '0);
  assign rd_count      = r_rd_count;
  assign busy          = (r_state != IDLE);
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_async_fifo_reader.sv
// Directed bench for async_fifo_reader with a behavioural FIFO read port.
module tb_async_fifo_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          r_clk = 1'b0;
  logic          rrst;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_read_error;
  logic          fifo_r_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] rd_count;
  logic          busy;
  logic          underflow_err;

  logic [DW-1:0] mem [256];
  logic          err [256];
  int unsigned   wp = 0;
  int unsigned   rp = 0;

  int tests = 0;
  int fails = 0;

  always #5 r_clk = ~r_clk;

  async_fifo_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .r_clk           (r_clk),
    .rrst            (rrst),
    .enable          (enable),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .fifo_read_error (fifo_read_error),
    .fifo_r_en       (fifo_r_en),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_ready         (m_ready),
    .rd_count        (rd_count),
    .busy            (busy),
    .underflow_err   (underflow_err)
  );

  // FIFO read port model: registered data_out/read_error, reset flushes it.
  assign fifo_empty = (rp == wp);
  always @(posedge r_clk) begin
    if (rrst) begin
      rp              <= wp;
      fifo_data       <= '0;
      fifo_read_error <= 1'b0;
    end else if (fifo_r_en) begin
      fifo_data       <= mem[8'(rp)];
      fifo_read_error <= err[8'(rp)];
      rp              <= rp + 1;
    end else begin
      fifo_read_error <= 1'b0;
    end
  end

  task automatic push(input logic [DW-1:0] d, input logic e);
    mem[8'(wp)] = d;
    err[8'(wp)] = e;
    wp = wp + 1;
  endtask

  task automatic test_reset();
    rrst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    @(posedge r_clk); #1;
    @(negedge r_clk);
    tests++; if (fifo_r_en !== 1'b0) begin fails++; $display("FAIL reset_r_en: got %b want 0", fifo_r_en); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    tests++; if (rd_count !== 16'h0000) begin fails++; $display("FAIL reset_rd_count: got %h want 0000", rd_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %b want 0", underflow_err); end
    @(posedge r_clk); #1;
    rrst = 1'b0;
  endtask

  task automatic test_basic_stream();
    logic          ren_e [7];
    logic          val_e [7];
    logic          bsy_e [7];
    logic [DW-1:0] dat_e [7];
    logic [CW-1:0] cnt_e [7];
    ren_e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    val_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bsy_e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    dat_e = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    cnt_e = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3};
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge r_clk);
      tests++; if (fifo_r_en !== ren_e[c]) begin fails++; $display("FAIL basic_r_en cyc%0d: got %b want %b", c, fifo_r_en, ren_e[c]); end
      tests++; if (m_valid !== val_e[c]) begin fails++; $display("FAIL basic_m_valid cyc%0d: got %b want %b", c, m_valid, val_e[c]); end
      if (val_e[c]) begin
        tests++; if (m_data !== dat_e[c]) begin fails++; $display("FAIL basic_m_data cyc%0d: got %h want %h", c, m_data, dat_e[c]); end
      end
      tests++; if (rd_count !== cnt_e[c]) begin fails++; $display("FAIL basic_rd_count cyc%0d: got %0d want %0d", c, rd_count, cnt_e[c]); end
      tests++; if (busy !== bsy_e[c]) begin fails++; $display("FAIL basic_busy cyc%0d: got %b want %b", c, busy, bsy_e[c]); end
      @(posedge r_clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic          rdy_i [11];
    logic          ren_e [11];
    logic          val_e [11];
    logic [DW-1:0] dat_e [11];
    logic [CW-1:0] cnt_e [11];
    rdy_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ren_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    val_e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dat_e = '{8'h00, 8'h00, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00};
    cnt_e = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0); push(8'hA4, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 11; c++) begin
      m_ready = rdy_i[c];
      @(negedge r_clk);
      tests++; if (fifo_r_en !== ren_e[c]) begin fails++; $display("FAIL bp_r_en cyc%0d: got %b want %b", c, fifo_r_en, ren_e[c]); end
      tests++; if (m_valid !== val_e[c]) begin fails++; $display("FAIL bp_m_valid cyc%0d: got %b want %b", c, m_valid, val_e[c]); end
      if (val_e[c]) begin
        tests++; if (m_data !== dat_e[c]) begin fails++; $display("FAIL bp_m_data cyc%0d: got %h want %h", c, m_data, dat_e[c]); end
      end
      tests++; if (rd_count !== cnt_e[c]) begin fails++; $display("FAIL bp_rd_count cyc%0d: got %0d want %0d", c, rd_count, cnt_e[c]); end
      @(posedge r_clk); #1;
    end
  endtask

  task automatic test_drain();
    logic          en_i  [7];
    logic          rdy_i [7];
    logic          ren_e [7];
    logic          val_e [7];
    logic          bsy_e [7];
    logic [DW-1:0] dat_e [7];
    logic [CW-1:0] cnt_e [7];
    en_i  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rdy_i = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ren_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    val_e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bsy_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    dat_e = '{8'h00, 8'h00, 8'hB1, 8'hB2, 8'h00, 8'h00, 8'h00};
    cnt_e = '{16'd7, 16'd7, 16'd7, 16'd8, 16'd9, 16'd9, 16'd9};
    push(8'hB1, 1'b0); push(8'hB2, 1'b0); push(8'hB3, 1'b0);
    for (int c = 0; c < 7; c++) begin
      enable  = en_i[c];
      m_ready = rdy_i[c];
      @(negedge r_clk);
      tests++; if (fifo_r_en !== ren_e[c]) begin fails++; $display("FAIL drain_r_en cyc%0d: got %b want %b", c, fifo_r_en, ren_e[c]); end
      tests++; if (m_valid !== val_e[c]) begin fails++; $display("FAIL drain_m_valid cyc%0d: got %b want %b", c, m_valid, val_e[c]); end
      if (val_e[c]) begin
        tests++; if (m_data !== dat_e[c]) begin fails++; $display("FAIL drain_m_data cyc%0d: got %h want %h", c, m_data, dat_e[c]); end
      end
      tests++; if (rd_count !== cnt_e[c]) begin fails++; $display("FAIL drain_rd_count cyc%0d: got %0d want %0d", c, rd_count, cnt_e[c]); end
      tests++; if (busy !== bsy_e[c]) begin fails++; $display("FAIL drain_busy cyc%0d: got %b want %b", c, busy, bsy_e[c]); end
      @(posedge r_clk); #1;
    end
  endtask

  // 0xB3 is still queued from the drain test; 0xC1 comes back flagged.
  task automatic test_read_error();
    logic          ren_e [8];
    logic          val_e [8];
    logic          uf_e  [8];
    logic [DW-1:0] dat_e [8];
    logic [CW-1:0] cnt_e [8];
    ren_e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    val_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    uf_e  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    dat_e = '{8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hC2, 8'hC3, 8'h00};
    cnt_e = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd10, 16'd10, 16'd11, 16'd12};
    push(8'hC1, 1'b1); push(8'hC2, 1'b0); push(8'hC3, 1'b0);
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge r_clk);
      tests++; if (fifo_r_en !== ren_e[c]) begin fails++; $display("FAIL rderr_r_en cyc%0d: got %b want %b", c, fifo_r_en, ren_e[c]); end
      tests++; if (m_valid !== val_e[c]) begin fails++; $display("FAIL rderr_m_valid cyc%0d: got %b want %b", c, m_valid, val_e[c]); end
      if (val_e[c]) begin
        tests++; if (m_data !== dat_e[c]) begin fails++; $display("FAIL rderr_m_data cyc%0d: got %h want %h", c, m_data, dat_e[c]); end
      end
      tests++; if (rd_count !== cnt_e[c]) begin fails++; $display("FAIL rderr_rd_count cyc%0d: got %0d want %0d", c, rd_count, cnt_e[c]); end
      tests++; if (underflow_err !== uf_e[c]) begin fails++; $display("FAIL rderr_underflow cyc%0d: got %b want %b", c, underflow_err, uf_e[c]); end
      @(posedge r_clk); #1;
    end
  endtask

  // Reset while one word is buffered, one is in flight and a third pop fires.
  task automatic test_reset_midop();
    push(8'hD1, 1'b0); push(8'hD2, 1'b0); push(8'hD3, 1'b0); push(8'hD4, 1'b0);
    enable = 1'b1; m_ready = 1'b1;
    @(posedge r_clk); #1;
    @(posedge r_clk); #1;
    rrst = 1'b1;
    @(negedge r_clk);
    tests++; if (fifo_r_en !== 1'b1) begin fails++; $display("FAIL midrst_pre_r_en: got %b want 1", fifo_r_en); end
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre_m_valid: got %b want 1", m_valid); end
    tests++; if (m_data !== 8'hD1) begin fails++; $display("FAIL midrst_pre_m_data: got %h want d1", m_data); end
    tests++; if (underflow_err !== 1'b1) begin fails++; $display("FAIL midrst_pre_underflow: got %b want 1", underflow_err); end
    @(posedge r_clk); #1;
    rrst = 1'b0;
    @(negedge r_clk);
    tests++; if (fifo_r_en !== 1'b0) begin fails++; $display("FAIL midrst_r_en: got %b want 0", fifo_r_en); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL midrst_m_data: got %h want 00", m_data); end
    tests++; if (rd_count !== 16'h0000) begin fails++; $display("FAIL midrst_rd_count: got %h want 0000", rd_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL midrst_underflow: got %b want 0", underflow_err); end
    @(posedge r_clk); #1;
  endtask

  task automatic test_count_wrap();
    logic          ren_e [4];
    logic          val_e [4];
    logic [CW-1:0] cnt_e [4];
    ren_e = '{1'b1, 1'b0, 1'b0, 1'b0};
    val_e = '{1'b0, 1'b0, 1'b1, 1'b0};
    cnt_e = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 256; i++) err[i] = 1'b0;
    enable = 1'b1; m_ready = 1'b1;
    wp = wp + 32'd65535;
    for (int i = 0; i < 70000 && rd_count !== 16'hFFFF; i++) begin
      @(posedge r_clk); #1;
    end
    tests++; if (rd_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h want ffff (timeout)", rd_count); end
    repeat (3) begin @(posedge r_clk); #1; end
    push(8'h5A, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge r_clk);
      tests++; if (fifo_r_en !== ren_e[c]) begin fails++; $display("FAIL wrap_r_en cyc%0d: got %b want %b", c, fifo_r_en, ren_e[c]); end
      tests++; if (m_valid !== val_e[c]) begin fails++; $display("FAIL wrap_m_valid cyc%0d: got %b want %b", c, m_valid, val_e[c]); end
      if (val_e[c]) begin
        tests++; if (m_data !== 8'h5A) begin fails++; $display("FAIL wrap_m_data cyc%0d: got %h want 5a", c, m_data); end
      end
      tests++; if (rd_count !== cnt_e[c]) begin fails++; $display("FAIL wrap_rd_count cyc%0d: got %h want %h", c, rd_count, cnt_e[c]); end
      @(posedge r_clk); #1;
    end
  endtask

  initial begin
    rrst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; err[i] = 1'b0; end
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_drain();
    test_read_error();
    test_reset_midop();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
